// File: rtl/pipe_pkg.sv
// EX->MEM pipeline shared types: payload bundle and skid-buffer states.
// Widths: DW datapath, AW register index, IW diff-test instruction.
package pipe_pkg;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int IW = 32;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [DW-1:0] rs2;
    logic [AW-1:0] rdid;
    logic          rdwen;
    logic [2:0]    func3;
    logic          lden;
    logic          sten;
    logic [DW-1:0] pc;
    logic [DW-1:0] csr_wdata;
    logic          except_en;
    logic [DW-1:0] except_code;
    logic          mret;
    logic [IW-1:0] diffins;
  } ex_mem_pld_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ex_mem_st_e;

endpackage

// File: rtl/stl_skid_buf.sv
// Generic 2-entry FIFO skid buffer; in_ready_o and out_valid_o come
// straight from flops. Ports: clk/rst_n, flush, in_* (EX), out_* (MEM).
module stl_skid_buf
  import pipe_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  ex_mem_st_e st_q, st_d;
  T           m_q, m_d;
  T           s_q, s_d;
  logic       m_vld_q, m_vld_d;
  logic       rdy_q, rdy_d;
  logic       acc, dlv;

  assign acc = in_valid_i & rdy_q & ~flush;
  assign dlv = m_vld_q & out_ready_i;

  always_comb begin
    st_d = st_q;
    m_d  = m_q;
    s_d  = s_q;
    if (flush) begin
      st_d = EMPTY;
    end else begin
      unique case (st_q)
        EMPTY: begin
          if (acc) begin
            m_d  = in_data_i;
            st_d = ONE;
          end
        end
        ONE: begin
          if (acc && !dlv) begin
            s_d  = in_data_i;
            st_d = TWO;
          end else if (acc && dlv) begin
            m_d = in_data_i;
          end else if (dlv) begin
            st_d = EMPTY;
          end
        end
        TWO: begin
          if (dlv) begin
            m_d  = s_q;
            s_d  = '0;
            st_d = ONE;
          end
        end
        default: st_d = EMPTY;
      endcase
    end
    // flags are pure functions of the next state
    m_vld_d = (st_d != EMPTY);
    rdy_d   = (st_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      st_q    <= st_d;
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = m_vld_q;
  assign out_data_o  = m_q;

endmodule

// File: rtl/pipe_ex_mem.sv
// EX->MEM pipeline register: packs EX results, buffers them in a skid
// buffer, qualifies control outputs. Option: PIPE_EX_MEM_PERF_EN adds o_stall_cnt.
module pipe_ex_mem
  import pipe_pkg::*;
#(
  parameter int DW = pipe_pkg::DW,
  parameter int AW = pipe_pkg::AW,
  parameter int IW = pipe_pkg::IW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          flush,
  input  logic          exe_valid_i,
  output logic          exe_ready_o,
  output logic          mem_valid_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] i_exu_res,
  input  logic [DW-1:0] i_exu_rs2,
  input  logic [AW-1:0] i_exu_rdid,
  input  logic          i_exu_rdwen,
  input  logic [2:0]    i_exu_func3,
  input  logic          i_exu_lden,
  input  logic          i_exu_sten,
  input  logic [DW-1:0] i_exu_pc,
  input  logic [DW-1:0] i_ex_csr_wdata,
  input  logic          i_ex_except_en,
  input  logic [DW-1:0] i_ex_except_code,
  input  logic          i_ex_mret,
  input  logic [IW-1:0] s_exu_diffins,
  output logic [DW-1:0] o_mem_res,
  output logic [DW-1:0] o_mem_rs2,
  output logic [AW-1:0] o_mem_rdid,
  output logic          o_mem_rdwen,
  output logic [2:0]    o_mem_func3,
  output logic          o_mem_lden,
  output logic          o_mem_sten,
  output logic [DW-1:0] o_mem_pc,
  output logic [DW-1:0] o_mem_csr_wdata,
  output logic          o_mem_except_en,
  output logic [DW-1:0] o_mem_except_code,
  output logic          o_mem_mret,
  output logic [IW-1:0] s_mem_diffins
`ifdef PIPE_EX_MEM_PERF_EN
  ,
  output logic [31:0]   o_stall_cnt
`endif
);

  ex_mem_pld_t in_pld, out_pld;
  logic        m_vld;

  always_comb begin
    in_pld             = '0;
    in_pld.res         = i_exu_res;
    in_pld.rs2         = i_exu_rs2;
    in_pld.rdid        = i_exu_rdid;
    in_pld.rdwen       = i_exu_rdwen;
    in_pld.func3       = i_exu_func3;
    in_pld.lden        = i_exu_lden;
    in_pld.sten        = i_exu_sten;
    in_pld.pc          = i_exu_pc;
    in_pld.csr_wdata   = i_ex_csr_wdata;
    in_pld.except_en   = i_ex_except_en;
    in_pld.except_code = i_ex_except_code;
    in_pld.mret        = i_ex_mret;
    in_pld.diffins     = s_exu_diffins;
  end

  stl_skid_buf #(
    .T (ex_mem_pld_t)
  ) u_skid (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .flush       (flush),
    .in_valid_i  (exe_valid_i),
    .in_ready_o  (exe_ready_o),
    .in_data_i   (in_pld),
    .out_valid_o (m_vld),
    .out_ready_i (mem_ready_i),
    .out_data_o  (out_pld)
  );

  assign mem_valid_o = m_vld;

  // side-effect fields are gated so a stale entry never fires in MEM
  assign o_mem_res         = out_pld.res;
  assign o_mem_rs2         = out_pld.rs2;
  assign o_mem_rdid        = out_pld.rdid;
  assign o_mem_rdwen       = out_pld.rdwen & m_vld;
  assign o_mem_func3       = out_pld.func3;
  assign o_mem_lden        = out_pld.lden & m_vld;
  assign o_mem_sten        = out_pld.sten & m_vld;
  assign o_mem_pc          = out_pld.pc;
  assign o_mem_csr_wdata   = out_pld.csr_wdata;
  assign o_mem_except_en   = out_pld.except_en & m_vld;
  assign o_mem_except_code = out_pld.except_code;
  assign o_mem_mret        = out_pld.mret & m_vld;
  assign s_mem_diffins     = m_vld ? out_pld.diffins : '0;

`ifdef PIPE_EX_MEM_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (exe_valid_i && !exe_ready_o) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Testbench for pipe_ex_mem: directed scenarios plus random traffic
// checked against a capacity-2 FIFO model.
module tb_pipe_ex_mem;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic flush, exe_valid_i, exe_ready_o, mem_valid_o, mem_ready_i;
  ex_mem_pld_t in_p, out_p;
`ifdef PIPE_EX_MEM_PERF_EN
  logic [31:0] stall_cnt;
`endif

  pipe_ex_mem dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .flush             (flush),
    .exe_valid_i       (exe_valid_i),
    .exe_ready_o       (exe_ready_o),
    .mem_valid_o       (mem_valid_o),
    .mem_ready_i       (mem_ready_i),
    .i_exu_res         (in_p.res),
    .i_exu_rs2         (in_p.rs2),
    .i_exu_rdid        (in_p.rdid),
    .i_exu_rdwen       (in_p.rdwen),
    .i_exu_func3       (in_p.func3),
    .i_exu_lden        (in_p.lden),
    .i_exu_sten        (in_p.sten),
    .i_exu_pc          (in_p.pc),
    .i_ex_csr_wdata    (in_p.csr_wdata),
    .i_ex_except_en    (in_p.except_en),
    .i_ex_except_code  (in_p.except_code),
    .i_ex_mret         (in_p.mret),
    .s_exu_diffins     (in_p.diffins),
    .o_mem_res         (out_p.res),
    .o_mem_rs2         (out_p.rs2),
    .o_mem_rdid        (out_p.rdid),
    .o_mem_rdwen       (out_p.rdwen),
    .o_mem_func3       (out_p.func3),
    .o_mem_lden        (out_p.lden),
    .o_mem_sten        (out_p.sten),
    .o_mem_pc          (out_p.pc),
    .o_mem_csr_wdata   (out_p.csr_wdata),
    .o_mem_except_en   (out_p.except_en),
    .o_mem_except_code (out_p.except_code),
    .o_mem_mret        (out_p.mret),
    .s_mem_diffins     (out_p.diffins)
`ifdef PIPE_EX_MEM_PERF_EN
    ,
    .o_stall_cnt       (stall_cnt)
`endif
  );

  int runs = 0;
  int fails = 0;
  ex_mem_pld_t q[$];

  function automatic ex_mem_pld_t rnd_pld(logic [63:0] res);
    ex_mem_pld_t p;
    p.res         = res;
    p.rs2         = {$urandom, $urandom};
    p.rdid        = 5'($urandom);
    p.rdwen       = 1'($urandom);
    p.func3       = 3'($urandom);
    p.lden        = 1'($urandom);
    p.sten        = 1'($urandom);
    p.pc          = {$urandom, $urandom};
    p.csr_wdata   = {$urandom, $urandom};
    p.except_en   = 1'($urandom);
    p.except_code = {$urandom, $urandom};
    p.mret        = 1'($urandom);
    p.diffins     = $urandom;
    return p;
  endfunction

  // one clock: drive, advance, update the FIFO model (capacity 2)
  task automatic cyc(bit v, bit r, bit f, ex_mem_pld_t p);
    int sz0;
    exe_valid_i = v;
    mem_ready_i = r;
    flush       = f;
    in_p        = p;
    sz0 = q.size();
    @(posedge clk);
    if (sz0 > 0 && r) void'(q.pop_front());
    if (f) q.delete();
    else if (v && sz0 < 2) q.push_back(p);
    #1;
  endtask

  task automatic test_reset;
    exe_valid_i = 0; mem_ready_i = 0; flush = 0; in_p = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    q.delete();
    cyc(0, 0, 0, '0);
    runs++;
    if (mem_valid_o !== 1'b0) begin
      fails++; $display("FAIL rst_valid got=%b exp=0", mem_valid_o);
    end
    runs++;
    if (exe_ready_o !== 1'b1) begin
      fails++; $display("FAIL rst_ready got=%b exp=1", exe_ready_o);
    end
    runs++;
    if (out_p.rdwen !== 1'b0) begin
      fails++; $display("FAIL rst_rdwen got=%b exp=0", out_p.rdwen);
    end
    runs++;
    if (out_p !== '0) begin
      fails++; $display("FAIL rst_outputs got=%h exp=0", out_p);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, rnd_pld(64'(i)));
      runs++;
      if (mem_valid_o !== 1'b1 || out_p.res !== 64'(i)) begin
        fails++;
        $display("FAIL b2b_%0d got v=%b res=%0h exp v=1 res=%0h",
                 i, mem_valid_o, out_p.res, i);
      end
      runs++;
      if (out_p !== q[0] || exe_ready_o !== 1'b1) begin
        fails++;
        $display("FAIL b2b_pld_%0d got=%h rdy=%b exp=%h rdy=1",
                 i, out_p, exe_ready_o, q[0]);
      end
    end
    cyc(0, 1, 0, '0);
    runs++;
    if (mem_valid_o !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got=%b exp=0", mem_valid_o);
    end
  endtask

  task automatic test_stall;
    ex_mem_pld_t a, b, c;
    a = rnd_pld(64'h10);
    b = rnd_pld(64'h20);
    c = rnd_pld(64'h30);
    cyc(1, 0, 0, a);
    runs++;
    if (out_p !== a || exe_ready_o !== 1'b1) begin
      fails++; $display("FAIL stall_a got=%h rdy=%b exp=%h rdy=1", out_p, exe_ready_o, a);
    end
    cyc(1, 0, 0, b);
    runs++;
    if (exe_ready_o !== 1'b0) begin
      fails++; $display("FAIL stall_full got=%b exp=0", exe_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, c);
      runs++;
      if (out_p !== a || mem_valid_o !== 1'b1 || exe_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold_%0d got=%h v=%b rdy=%b exp=%h v=1 rdy=0",
                 i, out_p, mem_valid_o, exe_ready_o, a);
      end
    end
    cyc(1, 1, 0, c);
    runs++;
    if (out_p !== b || exe_ready_o !== 1'b1) begin
      fails++; $display("FAIL stall_b got=%h rdy=%b exp=%h rdy=1", out_p, exe_ready_o, b);
    end
    cyc(1, 1, 0, c);
    runs++;
    if (out_p !== c || mem_valid_o !== 1'b1) begin
      fails++; $display("FAIL stall_c got=%h v=%b exp=%h v=1", out_p, mem_valid_o, c);
    end
    cyc(0, 1, 0, '0);
    runs++;
    if (mem_valid_o !== 1'b0 || q.size() != 0) begin
      fails++; $display("FAIL stall_drain got=%b exp=0", mem_valid_o);
    end
  endtask

  task automatic test_flush;
    cyc(1, 0, 0, rnd_pld(64'h41));
    cyc(1, 0, 0, rnd_pld(64'h42));
    cyc(1, 0, 1, rnd_pld(64'h43));
    runs++;
    if (mem_valid_o !== 1'b0 || exe_ready_o !== 1'b1) begin
      fails++; $display("FAIL flush got v=%b rdy=%b exp v=0 rdy=1", mem_valid_o, exe_ready_o);
    end
    runs++;
    if ({out_p.rdwen, out_p.lden, out_p.sten, out_p.except_en, out_p.mret} !== 5'b0 ||
        out_p.diffins !== '0) begin
      fails++; $display("FAIL flush_qual got=%h exp ctrl=0", out_p);
    end
    cyc(0, 1, 0, '0);
    runs++;
    if (mem_valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_drop got=%b exp=0", mem_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, rnd_pld(64'h51));
    cyc(1, 0, 0, rnd_pld(64'h52));
    rst_n = 0;
    #1;
    runs++;
    if (mem_valid_o !== 1'b0) begin
      fails++; $display("FAIL rst_mid_valid got=%b exp=0", mem_valid_o);
    end
    @(posedge clk);
    #1 rst_n = 1;
    q.delete();
    cyc(0, 0, 0, '0);
    runs++;
    if (exe_ready_o !== 1'b1 || mem_valid_o !== 1'b0) begin
      fails++; $display("FAIL rst_mid_rel got rdy=%b v=%b exp rdy=1 v=0", exe_ready_o, mem_valid_o);
    end
  endtask

  task automatic test_random;
    bit v, r, f;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 29) == 0);
      cyc(v, r, f, rnd_pld({$urandom, $urandom}));
      runs++;
      if (mem_valid_o !== (q.size() > 0) || exe_ready_o !== (q.size() < 2)) begin
        fails++;
        $display("FAIL rnd_flags_%0d got v=%b rdy=%b exp depth=%0d",
                 i, mem_valid_o, exe_ready_o, q.size());
      end else if (q.size() > 0) begin
        runs++;
        if (out_p !== q[0]) begin
          fails++; $display("FAIL rnd_pld_%0d got=%h exp=%h", i, out_p, q[0]);
        end
      end else begin
        runs++;
        if ({out_p.rdwen, out_p.lden, out_p.sten, out_p.except_en, out_p.mret} !== 5'b0 ||
            out_p.diffins !== '0) begin
          fails++; $display("FAIL rnd_qual_%0d got=%h exp ctrl=0", i, out_p);
        end
      end
    end
    cyc(0, 1, 0, '0);
    cyc(0, 1, 0, '0);
  endtask

`ifdef PIPE_EX_MEM_PERF_EN
  task automatic test_perf;
    logic [31:0] base;
    cyc(1, 0, 0, rnd_pld(64'h61));
    cyc(1, 0, 0, rnd_pld(64'h62));
    base = stall_cnt;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, rnd_pld(64'h63));
    runs++;
    if (stall_cnt - base !== 32'd5) begin
      fails++; $display("FAIL perf_cnt got=%0d exp=5", stall_cnt - base);
    end
    cyc(0, 1, 1, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_EX_MEM_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
